// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB memory slave.
// The bus-phase enum, bus widths and the wait-counter width are used by the top module.
package apb_mem_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   // Wide enough for WAIT_STATES in the range 0..15.
   localparam int unsigned WAIT_W = 4;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

endpackage

// File: rtl/apb_mem_array.sv
// Word-addressed single-port memory: synchronous write, registered read.
// A synchronous reset clears every word and the read register.
module apb_mem_array #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [Depth];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Read data is held until the next read or reset.
   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem_q[raddr_i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
         for (int i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rdata_q <= rdata_d;
         if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/modport_apb_mem.sv
// APB slave (no PSLVERR) fronting a word-addressed memory with WAIT_STATES access wait cycles.
// presetn is a synchronous, active-high reset despite its name.
module modport_apb_mem
   import apb_mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [APB_ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0]     pwdata,
   output logic                  pready,
   output logic [DATA_W-1:0]     prdata
);

   apb_state_e        state_q, state_d;
   apb_state_e        phase;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mem_we;
   logic              mem_re;

   // Upper address bits alias onto the same words.
   logic unused_paddr;
   assign unused_paddr = ^paddr[APB_ADDR_W-1:ADDR_W];

   // The setup cycle is recognised from the bus and resolved at its closing edge, so the
   // registered state only ever holds IDLE or ACCESS; this keeps transfers at two cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      mem_we  = 1'b0;
      mem_re  = 1'b0;
      phase   = (psel && !penable) ? SETUP : state_q;

      case (phase)
         SETUP: begin
            idx_d   = paddr[ADDR_W-1:0];
            wr_d    = pwrite;
            wdata_d = pwdata;
            cnt_d   = WAIT_W'(WAIT_STATES);
            mem_re  = !pwrite;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - WAIT_W'(1);
               end else begin
                  mem_we  = wr_q;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (presetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
      end
   end

   assign pready = (state_q == ACCESS) && (cnt_q == '0);

   apb_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk_i   (pclk),
      .rst_i   (presetn),
      .we_i    (mem_we),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .re_i    (mem_re),
      .raddr_i (paddr[ADDR_W-1:0]),
      .rdata_o (prdata)
   );

endmodule

// File: tb/tb_modport_apb_mem.sv
// Self-checking bench: two slaves (0 and 2 wait states) on one master, checked against an
// array-based memory model with directed scenarios followed by random transfers.
module tb_modport_apb_mem;
   import apb_mem_pkg::*;

   logic  pclk = 1'b0;
   logic  presetn, psel, penable, pwrite;
   word_t paddr, pwdata;
   logic  pready0, pready2;
   word_t prdata0, prdata2;
   logic  psel0, psel2;
   logic  pready_m;
   word_t prdata_m;
   int    cur = 0;

   int    n_checks = 0;
   int    n_fail   = 0;
   word_t mdl [2][256];
   word_t last_rd [2];

   always #5 pclk = ~pclk;

   assign psel0    = psel && (cur == 0);
   assign psel2    = psel && (cur == 2);
   assign pready_m = (cur == 2) ? pready2 : pready0;
   assign prdata_m = (cur == 2) ? prdata2 : prdata0;

   modport_apb_mem #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dut0 (
      .pclk    (pclk),
      .presetn (presetn),
      .psel    (psel0),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pready  (pready0),
      .prdata  (prdata0)
   );

   modport_apb_mem #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(2)) dut2 (
      .pclk    (pclk),
      .presetn (presetn),
      .psel    (psel2),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .pready  (pready2),
      .prdata  (prdata2)
   );

   task automatic check(input string tag, input word_t obs, input word_t exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         last_rd[k] = '0;
         for (int a = 0; a < 256; a++) mdl[k][a] = '0;
      end
   endtask

   // One complete transfer on the currently selected slave, scored against the model.
   // Address and data are scrambled during the access phase; the slave must have latched them.
   task automatic do_xfer(input bit wr, input word_t addr, input word_t data, input string tag);
      int         k     = (cur == 2) ? 1 : 0;
      int         waits = 0;
      bit         done  = 1'b0;
      logic [7:0] idx   = addr[7:0];
      word_t      exp   = wr ? last_rd[k] : mdl[k][idx];
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      tick();
      penable = 1'b1;
      paddr   = $urandom;
      pwdata  = $urandom;
      while (!done && waits <= 40) begin
         check({tag, "_prdata"}, prdata_m, exp);
         if (pready_m) done = 1'b1;
         else waits++;
         tick();
      end
      psel    = 1'b0;
      penable = 1'b0;
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_waits"}, 32'(waits), 32'(cur));
      if (wr) mdl[k][idx] = data;
      else last_rd[k] = exp;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      presetn = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      model_reset();
      tick();
      tick();
      presetn = 1'b0;
      check("rst_pready0", {31'b0, pready0}, 32'd0);
      check("rst_pready2", {31'b0, pready2}, 32'd0);
      check("rst_prdata0", prdata0, 32'h0);
      check("rst_prdata2", prdata2, 32'h0);

      // Reset contents, then penable without a setup phase must be ignored.
      cur = 0;
      do_xfer(1'b0, 32'h10, 32'h0, "rst_read");
      psel    = 1'b1;
      penable = 1'b1;
      tick();
      check("noset_pready_a", {31'b0, pready_m}, 32'd0);
      tick();
      check("noset_pready_b", {31'b0, pready_m}, 32'd0);
      psel    = 1'b0;
      penable = 1'b0;
      tick();

      do_xfer(1'b1, 32'h04, 32'hDEAD_BEEF, "wr04");
      do_xfer(1'b0, 32'h04, 32'h0, "rd04");
      do_xfer(1'b1, 32'h0000_0105, 32'h1234_5678, "wr_alias");
      do_xfer(1'b0, 32'h05, 32'h0, "rd_alias");

      cur = 2;
      do_xfer(1'b1, 32'h20, 32'hA5A5_A5A5, "ws_wr20");
      do_xfer(1'b0, 32'h20, 32'h0, "ws_rd20");
      cur = 0;

      // Master drops psel in the access phase: the write must not land.
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h30;
      pwdata  = 32'hFFFF_FFFF;
      tick();
      check("abort_pready_access", {31'b0, pready_m}, 32'd1);
      psel = 1'b0;
      tick();
      check("abort_pready_idle", {31'b0, pready_m}, 32'd0);
      do_xfer(1'b0, 32'h30, 32'h0, "abort_rd30");

      // Reset lands on the access edge of a write.
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 32'h08;
      pwdata  = 32'h1111_1111;
      tick();
      penable = 1'b1;
      presetn = 1'b1;
      tick();
      check("midrst_pready", {31'b0, pready_m}, 32'd0);
      check("midrst_prdata0", prdata0, 32'h0);
      check("midrst_prdata2", prdata2, 32'h0);
      presetn = 1'b0;
      psel    = 1'b0;
      penable = 1'b0;
      model_reset();
      tick();
      for (int a = 0; a < 256; a++) do_xfer(1'b0, 32'(a), 32'h0, "clr_rd");

      // Back-to-back writes then reads, no idle cycles between transfers.
      for (int a = 0; a < 16; a++) do_xfer(1'b1, 32'(a), 32'(a * 3), "b2b_wr");
      for (int a = 0; a < 16; a++) do_xfer(1'b0, 32'(a), 32'h0, "b2b_rd");
      tick();
      tick();
      check("b2b_hold", prdata_m, 32'd45);

      for (int n = 0; n < 300; n++) begin
         cur = ($urandom_range(0, 1) == 1) ? 2 : 0;
         do_xfer(1'($urandom_range(0, 1)), ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 31)),
                 $urandom, "rand");
         for (int w = $urandom_range(0, 2); w > 0; w--) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
